// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO registers.
// One multiplier/quotient bit per cycle: shift-add multiply, restoring divide.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_hi_we,
   input  logic             i_lo_we,
   input  logic [WIDTH-1:0] i_wdata,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t             r_state;
   logic [CW-1:0]      r_cnt;
   logic [1:0]         r_op;
   logic               r_sa, r_sb, r_bz;
   logic [WIDTH-1:0]   r_opnd;     // multiplicand (mul) or divisor (div), magnitude
   logic [WIDTH-1:0]   r_a_orig;
   logic [2*WIDTH-1:0] r_acc;      // product; low half doubles as dividend/quotient
   logic [WIDTH:0]     r_rem;
   logic [WIDTH-1:0]   r_hi, r_lo;
   logic               r_busy, r_done;

   logic               w_signed;
   logic [WIDTH-1:0]   w_mag_a, w_mag_b;
   logic [WIDTH:0]     w_msum;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH+1:0]   w_diff;
   logic               w_ge;
   logic [WIDTH-1:0]   w_quo, w_remv;

   assign w_signed = i_op[0];
   assign w_mag_a  = (w_signed && i_a[WIDTH-1]) ? -i_a : i_a;
   assign w_mag_b  = (w_signed && i_b[WIDTH-1]) ? -i_b : i_b;

   assign w_msum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);

   // Restoring step: try subtracting the divisor from the shifted remainder.
   assign w_shift  = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
   assign w_diff   = {1'b0, w_shift} - {2'b00, r_opnd};
   assign w_ge     = ~w_diff[WIDTH+1];

   assign w_quo    = r_acc[WIDTH-1:0];
   assign w_remv   = r_rem[WIDTH-1:0];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_op     <= '0;
         r_sa     <= 1'b0;
         r_sb     <= 1'b0;
         r_bz     <= 1'b0;
         r_opnd   <= '0;
         r_a_orig <= '0;
         r_acc    <= '0;
         r_rem    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_hi_we) r_hi <= i_wdata;
               if (i_lo_we) r_lo <= i_wdata;
               if (i_start) begin
                  r_op     <= i_op;
                  r_sa     <= w_signed & i_a[WIDTH-1];
                  r_sb     <= w_signed & i_b[WIDTH-1];
                  r_bz     <= (i_b == '0);
                  r_a_orig <= i_a;
                  r_cnt    <= '0;
                  r_rem    <= '0;
                  if (i_op[1]) begin
                     r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
                     r_opnd <= w_mag_b;
                  end else begin
                     r_acc  <= {{WIDTH{1'b0}}, w_mag_b};
                     r_opnd <= w_mag_a;
                  end
                  r_busy  <= 1'b1;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               if (r_op[1]) begin
                  r_rem <= w_ge ? w_diff[WIDTH:0] : w_shift;
                  r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_ge};
               end else begin
                  r_acc <= {w_msum, r_acc[WIDTH-1:1]};
               end
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(WIDTH-1)) begin
                  r_cnt   <= '0;
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               case (r_op)
                  2'b00: {r_hi, r_lo} <= r_acc;
                  2'b01: {r_hi, r_lo} <= (r_sa ^ r_sb) ? -r_acc : r_acc;
                  2'b10: begin
                     r_lo <= r_bz ? '1 : w_quo;
                     r_hi <= r_bz ? r_a_orig : w_remv;
                  end
                  default: begin
                     r_lo <= r_bz ? '1 : ((r_sa ^ r_sb) ? -w_quo : w_quo);
                     r_hi <= r_bz ? r_a_orig : (r_sa ? -w_remv : w_remv);
                  end
               endcase
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_hi   = r_hi;
   assign o_lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random ops
// compared against a plain-arithmetic HI/LO model.
module tb_mul_div_unit;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          i_rst, i_start, i_hi_we, i_lo_we;
   logic [1:0]    i_op;
   logic [W-1:0]  i_a, i_b, i_wdata;
   logic          o_busy, o_done;
   logic [W-1:0]  o_hi, o_lo;

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mul_div_unit #(.WIDTH(W)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_op(i_op),
      .i_a(i_a), .i_b(i_b), .i_hi_we(i_hi_we), .i_lo_we(i_lo_we),
      .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done),
      .o_hi(o_hi), .o_lo(o_lo)
   );

   // MIPS HI/LO semantics straight from integer arithmetic.
   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
      logic [63:0] p;
      longint sa, sb, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = '0;
      q  = 0;
      r  = 0;
      if (op == 2'b00) begin
         p = {32'b0, a} * {32'b0, b};
         hi = p[63:32]; lo = p[31:0];
      end else if (op == 2'b01) begin
         q = sa * sb;
         hi = q[63:32]; lo = q[31:0];
      end else if (b == 32'd0) begin
         lo = 32'hFFFF_FFFF; hi = a;
      end else if (op == 2'b10) begin
         lo = a / b; hi = a % b;
      end else begin
         q = sa / sb; r = sa % sb;
         lo = q[31:0]; hi = r[31:0];
      end
   endfunction

   // Drive a start for one cycle; called at a negedge, returns at the next.
   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      i_start = 1'b1; i_op = op; i_a = a; i_b = b;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   // Wait for o_done counting edges since the start edge; optionally inject
   // a start + MTLO at cycle inj to show they are ignored while busy.
   task automatic wait_done(input int inj, output int cyc, output int busyc, output bit ok);
      cyc = 0; busyc = 0; ok = 1'b0;
      while (cyc < 100) begin
         if (o_done) begin ok = 1'b1; break; end
         if (o_busy) busyc++;
         if (cyc == inj) begin
            i_start = 1'b1; i_lo_we = 1'b1; i_wdata = 32'hBAD0_BAD0;
            i_op = 2'b00; i_a = 32'h11; i_b = 32'h22;
         end else begin
            i_start = 1'b0; i_lo_we = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      i_start = 1'b0; i_lo_we = 1'b0;
   endtask

   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output int cyc, output int busyc, output bit ok);
      start_op(op, a, b);
      wait_done(-1, cyc, busyc, ok);
      hi = o_hi; lo = o_lo;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (o_busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
      checks++; if (o_done !== 1'b0) begin errs++; $display("FAIL reset_done got=%b exp=0", o_done); end
      checks++; if (o_hi !== 32'd0) begin errs++; $display("FAIL reset_hi got=%h exp=0", o_hi); end
      checks++; if (o_lo !== 32'd0) begin errs++; $display("FAIL reset_lo got=%h exp=0", o_lo); end
      i_rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_op(input string nm, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] hi, lo, ehi, elo;
      int cyc, busyc;
      bit ok;
      model(op, a, b, ehi, elo);
      do_op(op, a, b, hi, lo, cyc, busyc, ok);
      checks++; if (!ok || cyc != 33) begin errs++; $display("FAIL %s_latency got=%0d ok=%0d exp=33", nm, cyc, ok); end
      checks++; if (hi !== ehi) begin errs++; $display("FAIL %s_hi got=%h exp=%h", nm, hi, ehi); end
      checks++; if (lo !== elo) begin errs++; $display("FAIL %s_lo got=%h exp=%h", nm, lo, elo); end
   endtask

   task automatic test_multu();
      logic [31:0] hi, lo;
      int cyc, busyc;
      bit ok;
      do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, hi, lo, cyc, busyc, ok);
      checks++; if (!ok || cyc != 33) begin errs++; $display("FAIL multu_latency got=%0d exp=33", cyc); end
      checks++; if (busyc != 33) begin errs++; $display("FAIL multu_busy_cycles got=%0d exp=33", busyc); end
      checks++; if (hi !== 32'hFFFF_FFFE) begin errs++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
      checks++; if (lo !== 32'h0000_0001) begin errs++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
      checks++; if (o_busy !== 1'b0) begin errs++; $display("FAIL multu_busy_at_done got=%b exp=0", o_busy); end
      @(negedge clk);
      checks++; if (o_done !== 1'b0) begin errs++; $display("FAIL multu_done_pulse got=%b exp=0", o_done); end
   endtask

   task automatic test_mult_div();
      check_op("mult_neg3x5", 2'b01, 32'hFFFF_FFFD, 32'd5);
      @(negedge clk);
      check_op("div_neg7by2", 2'b11, 32'hFFFF_FFF9, 32'd2);
      @(negedge clk);
      check_op("div_minby_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
      @(negedge clk);
   endtask

   task automatic test_divzero_back_to_back();
      check_op("divu_by0", 2'b10, 32'd100, 32'd0);
      check_op("divu_b2b", 2'b10, 32'd100, 32'd7);
      @(negedge clk);
   endtask

   task automatic test_mt();
      int cyc, busyc;
      bit ok;
      i_hi_we = 1'b1; i_wdata = 32'h1234_5678;
      @(negedge clk);
      i_hi_we = 1'b0;
      checks++; if (o_hi !== 32'h1234_5678) begin errs++; $display("FAIL mthi got=%h exp=12345678", o_hi); end
      i_hi_we = 1'b1; i_lo_we = 1'b1; i_wdata = 32'hA5A5_0F0F;
      @(negedge clk);
      i_hi_we = 1'b0; i_lo_we = 1'b0;
      checks++; if (o_hi !== 32'hA5A5_0F0F || o_lo !== 32'hA5A5_0F0F) begin
         errs++; $display("FAIL mt_both got=%h/%h exp=a5a50f0f", o_hi, o_lo); end
      // MTLO coinciding with a start: the write lands, then the result overwrites it.
      i_lo_we = 1'b1; i_wdata = 32'h0000_DEAD;
      i_start = 1'b1; i_op = 2'b00; i_a = 32'd3; i_b = 32'd4;
      @(negedge clk);
      i_lo_we = 1'b0; i_start = 1'b0;
      checks++; if (o_lo !== 32'h0000_DEAD || o_busy !== 1'b1) begin
         errs++; $display("FAIL mt_with_start got=%h busy=%b exp=0000dead busy=1", o_lo, o_busy); end
      wait_done(-1, cyc, busyc, ok);
      checks++; if (!ok || o_lo !== 32'd12 || o_hi !== 32'd0) begin
         errs++; $display("FAIL mt_then_result got=%h/%h exp=0/c", o_hi, o_lo); end
      @(negedge clk);
   endtask

   task automatic test_ignore_while_busy();
      logic [31:0] ehi, elo;
      int cyc, busyc, dcnt;
      bit ok;
      model(2'b01, 32'hFFFF_FFFD, 32'd5, ehi, elo);
      start_op(2'b01, 32'hFFFF_FFFD, 32'd5);
      wait_done(5, cyc, busyc, ok);
      checks++; if (!ok || cyc != 33) begin errs++; $display("FAIL ignore_latency got=%0d exp=33", cyc); end
      checks++; if (o_hi !== ehi || o_lo !== elo) begin
         errs++; $display("FAIL ignore_result got=%h/%h exp=%h/%h", o_hi, o_lo, ehi, elo); end
      dcnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (o_busy || o_done) dcnt++;
      end
      checks++; if (dcnt != 0) begin errs++; $display("FAIL ignore_not_queued got=%0d busy/done cycles exp=0", dcnt); end
   endtask

   task automatic test_reset_mid();
      int dcnt;
      start_op(2'b01, 32'd6, 32'd7);
      repeat (9) @(negedge clk);
      i_rst = 1'b1;
      @(negedge clk);
      i_rst = 1'b0;
      checks++; if (o_busy !== 1'b0) begin errs++; $display("FAIL rstmid_busy got=%b exp=0", o_busy); end
      checks++; if (o_hi !== 32'd0 || o_lo !== 32'd0) begin
         errs++; $display("FAIL rstmid_hilo got=%h/%h exp=0/0", o_hi, o_lo); end
      dcnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (o_done) dcnt++;
      end
      checks++; if (dcnt != 0) begin errs++; $display("FAIL rstmid_no_done got=%0d exp=0", dcnt); end
      check_op("after_rst_multu", 2'b00, 32'd6, 32'd7);
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [1:0]  op;
      logic [31:0] a, b;
      for (int n = 0; n < 30; n++) begin
         op = 2'($urandom_range(0, 3));
         a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'd1;
            3: b = 32'($urandom_range(2, 300));
            default: b = $urandom;
         endcase
         check_op("random", op, a, b);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
   endtask

   initial begin
      i_rst = 1'b1; i_start = 1'b0; i_op = 2'b00; i_a = '0; i_b = '0;
      i_hi_we = 1'b0; i_lo_we = 1'b0; i_wdata = '0;
      test_reset();
      test_multu();
      test_mult_div();
      test_divzero_back_to_back();
      test_mt();
      test_ignore_while_busy();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
